// File: rtl/ray_step_generator_pkg.sv
// Shared constants and types for the ray-march point generator.
// Vectors are packed {x,y,z}, each lane 19-bit signed Q9.10.
package ray_step_generator_pkg;

  localparam int VECTOR_WIDTH = 57;
  localparam int COORD_WIDTH  = 19;
  localparam int FRAC_BITS    = 10;

  localparam int X_HI = 56;
  localparam int X_LO = 38;
  localparam int Y_HI = 37;
  localparam int Y_LO = 19;
  localparam int Z_HI = 18;
  localparam int Z_LO = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Lane add: carry out of bit 18 is dropped, so each lane wraps.
  function automatic logic [COORD_WIDTH-1:0] lane_add(
    input logic [COORD_WIDTH-1:0] a,
    input logic [COORD_WIDTH-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/ray_step_generator_vector_addition.sv
// Combinational lane-wise adder for packed {x,y,z} vectors.
// Lanes are independent: no carry crosses a lane boundary.
module vector_addition
  import ray_step_generator_pkg::*;
(
  input  logic [VECTOR_WIDTH-1:0] i_a,
  input  logic [VECTOR_WIDTH-1:0] i_b,
  output logic [VECTOR_WIDTH-1:0] o_sum
);

  always_comb begin
    o_sum = '0;
    o_sum[X_HI:X_LO] = lane_add(i_a[X_HI:X_LO], i_b[X_HI:X_LO]);
    o_sum[Y_HI:Y_LO] = lane_add(i_a[Y_HI:Y_LO], i_b[Y_HI:Y_LO]);
    o_sum[Z_HI:Z_LO] = lane_add(i_a[Z_HI:Z_LO], i_b[Z_HI:Z_LO]);
  end

endmodule

// File: rtl/ray_step_generator.sv
// Ray-march point generator: emits origin + k*dir for k = 1..N,
// one point per output handshake, sharing a single vector adder.
module ray_step_generator
  import ray_step_generator_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VECTOR_WIDTH-1:0] in_origin,
  input  logic [VECTOR_WIDTH-1:0] in_dir,
  input  logic [STEP_W-1:0]       in_steps,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VECTOR_WIDTH-1:0] out_point,
  output logic [STEP_W-1:0]       out_index,
  output logic                    out_last,
  output logic                    busy
);

  state_t                  r_state;
  logic [VECTOR_WIDTH-1:0] r_dir;
  logic [STEP_W-1:0]       r_n;

  logic [VECTOR_WIDTH-1:0] w_a;
  logic [VECTOR_WIDTH-1:0] w_b;
  logic [VECTOR_WIDTH-1:0] w_sum;
  logic [STEP_W-1:0]       w_next_idx;
  logic                    w_idle;

  assign w_idle     = (r_state == S_IDLE);
  assign in_ready   = w_idle;
  assign busy       = !w_idle;
  assign w_next_idx = out_index + STEP_W'(1);

  // First point comes from the request itself; later ones accumulate.
  assign w_a = w_idle ? in_origin : out_point;
  assign w_b = w_idle ? in_dir : r_dir;

  vector_addition u_vadd (
    .i_a  (w_a),
    .i_b  (w_b),
    .o_sum(w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dir     <= '0;
      r_n       <= '0;
      out_valid <= 1'b0;
      out_point <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && (in_steps != '0)) begin
            out_point <= w_sum;
            out_index <= STEP_W'(1);
            out_last  <= (in_steps == STEP_W'(1));
            out_valid <= 1'b1;
            r_dir     <= in_dir;
            r_n       <= in_steps;
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_valid && out_ready) begin
            if (!out_last) begin
              out_point <= w_sum;
              out_index <= w_next_idx;
              out_last  <= (w_next_idx == r_n);
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
